// File: rtl/avs_rom_reader.sv
// Avalon-MM read slave that fronts a synchronous ROM: queued commands, fixed wait-state latency, SLVERR on out-of-range beats.
// Optional multi-beat bursts are enabled by defining AVS_BURST_EN (adds the burstcount port and beat counter).
module avs_rom_reader #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int LATENCY  = 10,
  parameter int MAX_PEND = 4,
  parameter int BURST_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
`ifdef AVS_BURST_EN
  input  logic [BURST_W-1:0] burstcount,
`endif
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic [1:0]        response,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(LATENCY + 1);
`ifdef AVS_BURST_EN
  localparam int ENTRY_W = ADDR_W + BURST_W;
`else
  localparam int ENTRY_W = ADDR_W;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [ENTRY_W-1:0] q_mem [MAX_PEND];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic               full;
  logic               push, pop, last_beat, oor;
  logic [ENTRY_W-1:0] entry_in, head;
  logic [ADDR_W-1:0]  head_addr, cmd_addr;
  logic [LAT_W-1:0]   wait_cnt;
  logic               p1_valid, p1_oor;
`ifdef AVS_BURST_EN
  logic [BURST_W-1:0] head_beats, beats;

  // A zero burstcount is treated as a single beat.
  assign entry_in  = {address, (burstcount == {BURST_W{1'b0}}) ? BURST_W'(1) : burstcount};
  assign head_addr = head[ENTRY_W-1:BURST_W];
  assign head_beats = head[BURST_W-1:0];
  assign last_beat = (beats == BURST_W'(1));
`else
  assign entry_in  = address;
  assign head_addr = head;
  assign last_beat = 1'b1;
`endif

  assign push        = read & ~full;
  assign head        = q_mem[rd_ptr];
  assign waitrequest = full;
  assign oor         = ({1'b0, rom_addr} >= (ADDR_W + 1)'(DEPTH));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(MAX_PEND));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != {CNT_W{1'b0}}) begin
          pop        = 1'b1;
          next_state = WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt == LAT_W'(LATENCY - 1)) next_state = STREAM;
        else                                 next_state = WAIT;
      end
      STREAM: begin
        if (last_beat) next_state = IDLE;
        else           next_state = STREAM;
      end
      default: next_state = IDLE;
    endcase
  end

  // rom_addr is loaded on the last WAIT edge so the ROM samples the first beat during the first STREAM cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      cmd_addr <= '0;
      rom_addr <= '0;
      p1_valid <= 1'b0;
      p1_oor   <= 1'b0;
`ifdef AVS_BURST_EN
      beats    <= '0;
`endif
    end else begin
      p1_valid <= (state == STREAM);
      p1_oor   <= oor;
      case (state)
        IDLE: begin
          if (pop) begin
            cmd_addr <= head_addr;
            wait_cnt <= '0;
`ifdef AVS_BURST_EN
            beats    <= head_beats;
`endif
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + LAT_W'(1);
          if (next_state == STREAM) rom_addr <= cmd_addr;
        end
        STREAM: begin
          if (!last_beat) begin
            rom_addr <= rom_addr + ADDR_W'(1);
`ifdef AVS_BURST_EN
            beats    <= beats - BURST_W'(1);
`endif
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
      response      <= 2'b00;
    end else begin
      readdatavalid <= p1_valid;
      if (p1_valid) begin
        readdata <= p1_oor ? {DATA_W{1'b0}} : rom_q;
        response <= p1_oor ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_avs_rom_reader.sv
// Directed bench for avs_rom_reader (DEPTH=20): single reads, errors, back-pressure, reset abort, and bursts when AVS_BURST_EN is set.
module tb_avs_rom_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        read;
  logic        waitrequest;
  logic [63:0] readdata;
  logic        readdatavalid;
  logic [1:0]  response;
  logic [4:0]  rom_addr;
  logic [63:0] rom_q;
`ifdef AVS_BURST_EN
  logic [3:0]  burstcount;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic wait_seen;
  logic [63:0] got_data[$];
  logic [1:0]  got_resp[$];
  int          got_cyc[$];

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic [1:0]  resp;
  } vec_t;
  vec_t tv[7];

  avs_rom_reader #(.DEPTH(20)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .read(read),
`ifdef AVS_BURST_EN
    .burstcount(burstcount),
`endif
    .waitrequest(waitrequest),
    .readdata(readdata),
    .readdatavalid(readdatavalid),
    .response(response),
    .rom_addr(rom_addr),
    .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [4:0] a);
    return 64'hC0DE_0000_0000_0000 | {59'd0, a};
  endfunction

  always @(posedge clk) rom_q <= rom_word(rom_addr);
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (readdatavalid) begin
      got_data.push_back(readdata);
      got_resp.push_back(response);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_resp.delete();
    got_cyc.delete();
  endtask

  // Presents one command and returns the cycle stamp of its accepting edge; read is left high.
  task automatic issue(input logic [4:0] a, output int acc);
    int guard = 0;
    @(negedge clk);
    read = 1'b1;
    address = a;
    while (waitrequest && guard < 200) begin
      wait_seen = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: waitrequest stuck high for %0d cycles", guard);
    end
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  initial begin
    int acc;
    int acc_q[6];
    logic [4:0] bp_addr[6];

    tv[0] = '{5'd3,  64'hC0DE_0000_0000_0003, 2'b00};
    tv[1] = '{5'd25, 64'h0000_0000_0000_0000, 2'b10};
    tv[2] = '{5'd5,  64'hC0DE_0000_0000_0005, 2'b00};
    tv[3] = '{5'd19, 64'hC0DE_0000_0000_0013, 2'b00};
    tv[4] = '{5'd20, 64'h0000_0000_0000_0000, 2'b10};
    tv[5] = '{5'd31, 64'h0000_0000_0000_0000, 2'b10};
    tv[6] = '{5'd0,  64'hC0DE_0000_0000_0000, 2'b00};
    bp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7};

    reset_n = 1'b0;
    read = 1'b0;
    address = 5'd0;
    wait_seen = 1'b0;
`ifdef AVS_BURST_EN
    burstcount = 4'd1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", 64'(waitrequest), 64'd0);
    chk("rst_rdvalid", 64'(readdatavalid), 64'd0);
    chk("rst_readdata", readdata, 64'd0);
    chk("rst_response", 64'(response), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_mon();
      issue(tv[i].addr, acc);
      read = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      chk($sformatf("single_beats[%0d]", i), 64'(got_cyc.size()), 64'd1);
      chk($sformatf("single_latency[%0d]", i),
          64'(got_cyc.size() > 0 ? got_cyc[0] - acc : -1), 64'd13);
      chk($sformatf("single_data[%0d]", i), got_data.size() > 0 ? got_data[0] : 64'hx, tv[i].data);
      chk($sformatf("single_resp[%0d]", i), 64'(got_resp.size() > 0 ? got_resp[0] : 2'bxx), 64'(tv[i].resp));
      chk($sformatf("hold_readdata[%0d]", i), readdata, tv[i].data);
    end

    // Six back-to-back reads against a 4-deep queue.
    clear_mon();
    wait_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(bp_addr[i], acc_q[i]);
      if (i == 4) chk("bp_full_after_5th", 64'(waitrequest), 64'd1);
    end
    read = 1'b0;
    chk("bp_wait_seen", 64'(wait_seen), 64'd1);
    repeat (200) @(posedge clk);
    #2;
    chk("bp_count", 64'(got_cyc.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_data[%0d]", i), got_data.size() > i ? got_data[i] : 64'hx, rom_word(bp_addr[i]));
      chk($sformatf("bp_resp[%0d]", i), 64'(got_resp.size() > i ? got_resp[i] : 2'bxx), 64'd0);
    end

`ifdef AVS_BURST_EN
    // Burst wraps 30,31,0,1; the first two beats are beyond DEPTH and must not end the burst.
    clear_mon();
    burstcount = 4'd4;
    issue(5'd30, acc);
    read = 1'b0;
    burstcount = 4'd1;
    repeat (40) @(posedge clk);
    #2;
    chk("burst_beats", 64'(got_cyc.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("burst_cycle[%0d]", k), 64'(got_cyc.size() > k ? got_cyc[k] - acc : -1), 64'(13 + k));
    end
    chk("burst_d0", got_data.size() > 0 ? got_data[0] : 64'hx, 64'h0);
    chk("burst_r0", 64'(got_resp.size() > 0 ? got_resp[0] : 2'bxx), 64'd2);
    chk("burst_d1", got_data.size() > 1 ? got_data[1] : 64'hx, 64'h0);
    chk("burst_r1", 64'(got_resp.size() > 1 ? got_resp[1] : 2'bxx), 64'd2);
    chk("burst_d2", got_data.size() > 2 ? got_data[2] : 64'hx, 64'hC0DE_0000_0000_0000);
    chk("burst_r2", 64'(got_resp.size() > 2 ? got_resp[2] : 2'bxx), 64'd0);
    chk("burst_d3", got_data.size() > 3 ? got_data[3] : 64'hx, 64'hC0DE_0000_0000_0001);
    chk("burst_r3", 64'(got_resp.size() > 3 ? got_resp[3] : 2'bxx), 64'd0);

    clear_mon();
    burstcount = 4'd0;
    issue(5'd7, acc);
    read = 1'b0;
    burstcount = 4'd1;
    repeat (40) @(posedge clk);
    #2;
    chk("burst0_beats", 64'(got_cyc.size()), 64'd1);
    chk("burst0_data", got_data.size() > 0 ? got_data[0] : 64'hx, 64'hC0DE_0000_0000_0007);
`endif

    // Reset five cycles after two accepted commands must discard both.
    clear_mon();
    issue(5'd8, acc);
    issue(5'd9, acc);
    read = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_waitrequest", 64'(waitrequest), 64'd0);
    chk("abort_rdvalid", 64'(readdatavalid), 64'd0);
    chk("abort_readdata", readdata, 64'd0);
    chk("abort_response", 64'(response), 64'd0);
    chk("abort_rom_addr", 64'(rom_addr), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    chk("abort_no_valid", 64'(got_cyc.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
